// File: rtl/train_seq_pkg.sv
// Shared types and defaults for the training sequencer.
package train_seq_pkg;

  localparam int unsigned DEF_ROWS       = 3;
  localparam int unsigned DEF_MAX_LAYERS = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    FEED,
    DRAIN,
    BACKPROP,
    UPDATE,
    DONE
  } state_t;

  // A run always has at least one layer and never more than the array supports.
  function automatic int unsigned clamp_layers(input int unsigned n, input int unsigned max_l);
    if (n == 0) return 1;
    if (n > max_l) return max_l;
    return n;
  endfunction

endpackage

// File: rtl/train_seq_if.sv
// Host/datapath-facing signal bundle of the training sequencer.
interface train_seq_if #(
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned EPOCH_W = 16
) ();

  logic               enable;
  logic               start;
  logic               abort;
  logic [IDX_W-1:0]   cfg_layers;
  logic [EPOCH_W-1:0] cfg_epochs;
  logic               data_valid;

  logic [IDX_W-1:0]   w_layer_index;
  logic [IDX_W-1:0]   w_row_index;
  logic               is_load;
  logic               load_w;
  logic               i_is_load;
  logic               use_z;
  logic               backprop_cost;
  logic               is_update;
  logic               busy;
  logic               done;
  logic [EPOCH_W-1:0] epochs_left;

  modport master (
    output enable, start, abort, cfg_layers, cfg_epochs, data_valid,
    input  w_layer_index, w_row_index, is_load, load_w, i_is_load, use_z,
           backprop_cost, is_update, busy, done, epochs_left
  );

  modport slave (
    input  enable, start, abort, cfg_layers, cfg_epochs, data_valid,
    output w_layer_index, w_row_index, is_load, load_w, i_is_load, use_z,
           backprop_cost, is_update, busy, done, epochs_left
  );

endinterface

// File: rtl/train_seq_counter.sv
// Loadable up/down counter with clear, enable and a terminal-count compare.
module train_seq_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         up_i,
  input  logic [W-1:0] tc_val_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = up_i ? cnt_q + ONE : cnt_q - ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/train_sequencer.sv
// Training sequencer: walks weight-load, forward, drain, backprop and update
// phases over the configured layers and epochs using row/layer/epoch counters.
module train_sequencer
  import train_seq_pkg::*;
#(
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned MAX_LAYERS = DEF_MAX_LAYERS,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned EPOCH_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  train_seq_if.slave  bus
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   layers_q, layers_d;

  logic               row_clr, row_en, row_tc;
  logic [IDX_W-1:0]   row_cnt, row_tc_val;
  logic               lay_clr, lay_en, lay_up, lay_tc;
  logic [IDX_W-1:0]   lay_cnt, lay_tc_val;
  logic               ep_clr, ep_load, ep_en, ep_tc;
  logic [EPOCH_W-1:0] ep_cnt;

  // The row counter doubles as the drain-cycle counter.
  assign row_tc_val = (state_q == DRAIN) ? IDX_W'(2 * ROWS - 1) : IDX_W'(ROWS - 1);
  assign lay_tc_val = (state_q == BACKPROP) ? '0 : layers_q - IDX_W'(1);

  train_seq_counter #(.W(IDX_W)) u_row (
    .clk(clk), .rst_n(rst_n), .clr_i(row_clr), .load_i(1'b0), .load_val_i('0),
    .en_i(row_en), .up_i(1'b1), .tc_val_i(row_tc_val), .cnt_o(row_cnt), .tc_o(row_tc)
  );

  train_seq_counter #(.W(IDX_W)) u_layer (
    .clk(clk), .rst_n(rst_n), .clr_i(lay_clr), .load_i(1'b0), .load_val_i('0),
    .en_i(lay_en), .up_i(lay_up), .tc_val_i(lay_tc_val), .cnt_o(lay_cnt), .tc_o(lay_tc)
  );

  train_seq_counter #(.W(EPOCH_W)) u_epoch (
    .clk(clk), .rst_n(rst_n), .clr_i(ep_clr), .load_i(ep_load), .load_val_i(bus.cfg_epochs),
    .en_i(ep_en), .up_i(1'b0), .tc_val_i(EPOCH_W'(1)), .cnt_o(ep_cnt), .tc_o(ep_tc)
  );

  always_comb begin
    state_d  = state_q;
    layers_d = layers_q;
    row_clr  = 1'b0;
    row_en   = 1'b0;
    lay_clr  = 1'b0;
    lay_en   = 1'b0;
    lay_up   = 1'b1;
    ep_clr   = 1'b0;
    ep_load  = 1'b0;
    ep_en    = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      row_clr = 1'b1;
      lay_clr = 1'b1;
      ep_clr  = 1'b1;
    end else if (bus.enable) begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          layers_d = IDX_W'(clamp_layers(32'(bus.cfg_layers), MAX_LAYERS));
          ep_load  = 1'b1;
          row_clr  = 1'b1;
          lay_clr  = 1'b1;
          state_d  = (bus.cfg_epochs == '0) ? DONE : LOAD_W;
        end
        LOAD_W: begin
          row_en = 1'b1;
          if (row_tc) begin
            row_clr = 1'b1;
            state_d = FEED;
          end
        end
        FEED: if (lay_cnt != '0 || bus.data_valid) begin
          row_en = 1'b1;
          if (row_tc) begin
            row_clr = 1'b1;
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          row_en = 1'b1;
          if (row_tc) begin
            row_clr = 1'b1;
            if (lay_tc) state_d = BACKPROP;
            else begin
              lay_en  = 1'b1;
              state_d = LOAD_W;
            end
          end
        end
        BACKPROP: begin
          row_en = 1'b1;
          lay_up = 1'b0;
          if (row_tc) begin
            row_clr = 1'b1;
            if (lay_tc) state_d = UPDATE;
            else        lay_en  = 1'b1;
          end
        end
        UPDATE: begin
          row_en = 1'b1;
          if (row_tc) begin
            row_clr = 1'b1;
            if (lay_tc) begin
              lay_clr = 1'b1;
              ep_en   = 1'b1;
              state_d = ep_tc ? DONE : LOAD_W;
            end else begin
              lay_en = 1'b1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      layers_q <= '0;
    end else begin
      state_q  <= state_d;
      layers_q <= layers_d;
    end
  end

  always_comb begin
    bus.w_layer_index = '0;
    bus.w_row_index   = '0;
    bus.is_load       = 1'b0;
    bus.load_w        = 1'b0;
    bus.i_is_load     = 1'b0;
    bus.use_z         = 1'b0;
    bus.backprop_cost = 1'b0;
    bus.is_update     = 1'b0;
    bus.done          = 1'b0;
    bus.busy          = (state_q != IDLE);
    bus.epochs_left   = ep_cnt;
    if (bus.enable) begin
      unique case (state_q)
        LOAD_W: begin
          bus.is_load       = 1'b1;
          bus.load_w        = 1'b1;
          bus.w_layer_index = lay_cnt;
          bus.w_row_index   = row_cnt;
        end
        FEED: begin
          bus.w_layer_index = lay_cnt;
          bus.w_row_index   = row_cnt;
          if (lay_cnt == '0) bus.i_is_load = bus.data_valid;
          else               bus.use_z     = 1'b1;
        end
        BACKPROP: begin
          bus.backprop_cost = 1'b1;
          bus.use_z         = 1'b1;
          bus.w_layer_index = lay_cnt;
          bus.w_row_index   = row_cnt;
        end
        UPDATE: begin
          bus.is_update     = 1'b1;
          bus.w_layer_index = lay_cnt;
          bus.w_row_index   = row_cnt;
        end
        DONE:    bus.done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_train_sequencer.sv
// Self-checking bench: a phase-list reference model is consumed cycle by cycle.
module tb_train_sequencer;

  localparam int ROWS    = 3;
  localparam int MAXL    = 4;
  localparam int IDX_W   = 8;
  localparam int EPOCH_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  train_seq_if #(.IDX_W(IDX_W), .EPOCH_W(EPOCH_W)) bus ();

  train_sequencer #(.ROWS(ROWS), .MAX_LAYERS(MAXL), .IDX_W(IDX_W), .EPOCH_W(EPOCH_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef enum int {K_LOAD, K_FEED, K_DRAIN, K_BP, K_UPD, K_DONE} kind_t;
  typedef struct {
    kind_t kind;
    int    layer;
    int    row;
    int    ep;
  } slot_t;

  slot_t exp_q[$];
  int    bp_seen[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(bit busy, bit done, bit ld, bit lw, bit il, bit uz,
                                       bit bc, bit up, int lay, int row, int ep);
    logic [7:0]  l8  = lay[7:0];
    logic [7:0]  r8  = row[7:0];
    logic [15:0] e16 = ep[15:0];
    return {24'b0, busy, done, ld, lw, il, uz, bc, up, l8, r8, e16};
  endfunction

  function automatic logic [63:0] observed();
    return {24'b0, bus.busy, bus.done, bus.is_load, bus.load_w, bus.i_is_load, bus.use_z,
            bus.backprop_cost, bus.is_update, bus.w_layer_index, bus.w_row_index, bus.epochs_left};
  endfunction

  function automatic logic [63:0] expected(slot_t s, bit en, bit dv);
    if (!en) return pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, s.ep);
    case (s.kind)
      K_LOAD:  return pack(1, 0, 1, 1, 0, 0, 0, 0, s.layer, s.row, s.ep);
      K_FEED:  return pack(1, 0, 0, 0, (s.layer == 0) && dv, s.layer != 0, 0, 0, s.layer, s.row, s.ep);
      K_DRAIN: return pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, s.ep);
      K_BP:    return pack(1, 0, 0, 0, 0, 1, 1, 0, s.layer, s.row, s.ep);
      K_UPD:   return pack(1, 0, 0, 0, 0, 0, 0, 1, s.layer, s.row, s.ep);
      default: return pack(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endcase
  endfunction

  task automatic push(kind_t k, int l, int r, int ep);
    slot_t s;
    s.kind = k; s.layer = l; s.row = r; s.ep = ep;
    exp_q.push_back(s);
  endtask

  // One slot per productive cycle, generated straight from the phase rules.
  task automatic build_model(input int cfg_l, input int cfg_e);
    int nl;
    nl = (cfg_l == 0) ? 1 : (cfg_l > MAXL) ? MAXL : cfg_l;
    exp_q.delete();
    for (int e = 0; e < cfg_e; e++) begin
      for (int l = 0; l < nl; l++) begin
        for (int r = 0; r < ROWS; r++) push(K_LOAD, l, r, cfg_e - e);
        for (int r = 0; r < ROWS; r++) push(K_FEED, l, r, cfg_e - e);
        for (int r = 0; r < 2 * ROWS; r++) push(K_DRAIN, l, r, cfg_e - e);
      end
      for (int l = nl - 1; l >= 0; l--)
        for (int r = 0; r < ROWS; r++) push(K_BP, l, r, cfg_e - e);
      for (int l = 0; l < nl; l++)
        for (int r = 0; r < ROWS; r++) push(K_UPD, l, r, cfg_e - e);
    end
    push(K_DONE, 0, 0, 0);
  endtask

  // dv_mode: 0 high, 1 random, 2 five low cycles in first layer-0 FEED
  // en_mode: 0 high, 1 random, 2 low for cycles 10..13
  // special: 0 none, 1 abort (with start) in UPDATE row 1, 2 reset in FEED
  task automatic run(input int cfg_l, input int cfg_e, input int dv_mode, input int en_mode,
                     input int special, output int done_n);
    slot_t s;
    int    n;
    int    dv_low_left;
    bit    stop;
    bit    en, dv, ab;
    build_model(cfg_l, cfg_e);
    bp_seen.delete();
    done_n = -1;
    stop = 1'b0;
    dv_low_left = (dv_mode == 2) ? 5 : 0;
    bus.enable = 1'b1; bus.abort = 1'b0; bus.data_valid = 1'b1; bus.start = 1'b1;
    bus.cfg_layers = IDX_W'(cfg_l); bus.cfg_epochs = EPOCH_W'(cfg_e);
    @(negedge clk);
    check("idle_at_start", observed(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    n = 1;
    while (exp_q.size() > 0 && !stop) begin
      if (n > 3000) begin
        check("timeout", 64'(n), 64'(0));
        stop = 1'b1;
        break;
      end
      s  = exp_q[0];
      en = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? ($urandom_range(0, 7) != 0) : !(n >= 10 && n <= 13);
      if (dv_mode == 1) dv = ($urandom_range(0, 3) != 0);
      else if (s.kind == K_FEED && s.layer == 0 && dv_low_left > 0) begin
        dv = 1'b0;
        dv_low_left--;
      end else dv = 1'b1;
      ab = (special == 1) && s.kind == K_UPD && s.row == 1;
      if (special == 2 && s.kind == K_FEED) begin
        bus.enable = 1'b1; bus.data_valid = 1'b1; bus.start = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", observed(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        stop = 1'b1;
        break;
      end
      bus.enable = en; bus.data_valid = dv; bus.abort = ab;
      bus.start = ab ? 1'b1 : ($urandom_range(0, 9) == 0);
      @(negedge clk);
      check("cycle", observed(), expected(s, en, dv));
      if (bus.done) done_n = n;
      if (bus.backprop_cost) bp_seen.push_back(int'(bus.w_layer_index));
      if (ab) stop = 1'b1;
      else if (en && !(s.kind == K_FEED && s.layer == 0 && !dv)) void'(exp_q.pop_front());
      @(posedge clk); #1;
      n++;
    end
    exp_q.delete();
    bus.start = 1'b0; bus.abort = 1'b0; bus.enable = 1'b1; bus.data_valid = 1'b1;
    @(negedge clk);
    check("idle_after", observed(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    bus.enable = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
    bus.cfg_layers = '0; bus.cfg_epochs = '0; bus.data_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset_state", observed(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(2, 2, 0, 0, 0, dn);
    check("done_cycle_L2E2", 64'(dn), 64'(6 * 2 * ROWS * 2 + 1));

    run(2, 2, 2, 0, 0, dn);
    check("done_cycle_dv_stall", 64'(dn), 64'(6 * 2 * ROWS * 2 + 1 + 5));

    run(2, 2, 0, 2, 0, dn);
    check("done_cycle_enable_gap", 64'(dn), 64'(6 * 2 * ROWS * 2 + 1 + 4));

    run(3, 1, 0, 0, 0, dn);
    check("bp_count", 64'(bp_seen.size()), 64'(9));
    for (int i = 0; i < 9 && i < bp_seen.size(); i++)
      check("bp_order", 64'(bp_seen[i]), 64'(2 - i / 3));

    run(2, 2, 0, 0, 1, dn);
    check("abort_no_done", 64'(dn), 64'(-1));

    run(2, 0, 0, 0, 0, dn);
    check("zero_epochs_done", 64'(dn), 64'(1));

    run(9, 1, 0, 0, 0, dn);
    check("clamp_max", 64'(dn), 64'(6 * MAXL * ROWS + 1));

    run(0, 1, 0, 0, 0, dn);
    check("clamp_min", 64'(dn), 64'(6 * 1 * ROWS + 1));

    run(2, 2, 0, 0, 2, dn);
    run(1, 1, 0, 0, 0, dn);
    check("clean_after_reset", 64'(dn), 64'(6 * ROWS + 1));

    bus.cfg_layers = IDX_W'(2); bus.cfg_epochs = EPOCH_W'(1);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    check("abort_over_start", observed(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++)
      run($urandom_range(0, 6), $urandom_range(0, 3), 1, 1, 0, dn);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
